// File: rtl/reg_file_ctx_if.sv
// Register-file bus: write/read addressing, bulk-operation requests and status.
//   master: drives din, adr_x, adr_y, rf_wr, clr_req, save_req, restore_req
//   slave : drives dx_out, dy_out, busy, done, wr_drop
interface reg_file_ctx_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] adr_x;
  logic [ADDR_W-1:0] adr_y;
  logic              rf_wr;
  logic              clr_req;
  logic              save_req;
  logic              restore_req;
  logic [DATA_W-1:0] dx_out;
  logic [DATA_W-1:0] dy_out;
  logic              busy;
  logic              done;
  logic              wr_drop;

  modport master (
    output din, adr_x, adr_y, rf_wr, clr_req, save_req, restore_req,
    input  dx_out, dy_out, busy, done, wr_drop
  );

  modport slave (
    input  din, adr_x, adr_y, rf_wr, clr_req, save_req, restore_req,
    output dx_out, dy_out, busy, done, wr_drop
  );
endinterface

// File: rtl/reg_file_ctx.sv
// 2-read/1-write register file with a shadow bank for context save/restore
// and a sequenced bulk clear (one entry per clock).
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : reg_file_ctx_if slave -- write port (din/adr_x/rf_wr), async
//              reads (adr_x -> dx_out, adr_y -> dy_out), sweep requests
//              (clr_req > restore_req > save_req), status busy/done/wr_drop
module reg_file_ctx #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 0
) (
  input  logic           clk,
  input  logic           rst,
  reg_file_ctx_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, SAVE, RESTORE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] main_q   [DEPTH];
  logic [DATA_W-1:0] shadow_q [DEPTH];

  // Single write port into the main bank, shared by user writes and sweeps.
  logic              main_we;
  logic [ADDR_W-1:0] main_wa;
  logic [DATA_W-1:0] main_wd;
  logic              shadow_we;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    main_we   = 1'b0;
    main_wa   = bus.adr_x;
    main_wd   = bus.din;
    shadow_we = 1'b0;
    case (state_q)
      IDLE: begin
        // A write accepted alongside a request lands before the sweep starts.
        main_we = bus.rf_wr;
        idx_d   = '0;
        if (bus.clr_req)          state_d = CLEAR;
        else if (bus.restore_req) state_d = RESTORE;
        else if (bus.save_req)    state_d = SAVE;
      end
      CLEAR: begin
        main_we = 1'b1;
        main_wa = idx_q;
        main_wd = '0;
      end
      SAVE: shadow_we = 1'b1;
      RESTORE: begin
        main_we = 1'b1;
        main_wa = idx_q;
        main_wd = shadow_q[idx_q];
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST) begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end
    busy_d = (state_d != IDLE);
    done_d = (state_q != IDLE) && (idx_q == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (main_we)   main_q[main_wa] <= main_wd;
      if (shadow_we) shadow_q[idx_q] <= main_q[idx_q];
    end
  end

  // Forwarding only applies to writes that will actually be performed.
  logic fwd;
  always_comb begin
    fwd         = (BYPASS != 0) && bus.rf_wr && !busy_q;
    bus.dx_out  = fwd ? bus.din : main_q[bus.adr_x];
    bus.dy_out  = (fwd && (bus.adr_y == bus.adr_x)) ? bus.din : main_q[bus.adr_y];
    bus.busy    = busy_q;
    bus.done    = done_q;
    bus.wr_drop = bus.rf_wr && busy_q;
  end
endmodule

// File: tb/tb_reg_file_ctx.sv
module tb_reg_file_ctx;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_ctx_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  reg_file_ctx_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  reg_file_ctx #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_nb (.clk(clk), .rst(rst), .bus(bus0));
  reg_file_ctx #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_b  (.clk(clk), .rst(rst), .bus(bus1));

  assign bus1.din         = bus0.din;
  assign bus1.adr_x       = bus0.adr_x;
  assign bus1.adr_y       = bus0.adr_y;
  assign bus1.rf_wr       = bus0.rf_wr;
  assign bus1.clr_req     = bus0.clr_req;
  assign bus1.save_req    = bus0.save_req;
  assign bus1.restore_req = bus0.restore_req;

  int checks = 0;
  int errors = 0;

  // Reference model: bank contents plus a snapshot of the sweep's final result.
  logic [DW-1:0] mm [DEPTH];
  logic [DW-1:0] ms [DEPTH];
  logic [DW-1:0] post [DEPTH];
  bit active = 0;
  bit done_e = 0;
  int op = 0;   // 0 clear, 1 save, 2 restore
  int k  = 0;   // entries already swept

  logic [37:0] act_vec;
  assign act_vec = {bus0.dx_out, bus0.dy_out, bus1.dx_out, bus1.dy_out,
                    bus0.busy, bus0.done, bus0.wr_drop,
                    bus1.busy, bus1.done, bus1.wr_drop};

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (active && op != 1 && a < k) return post[a];
    return mm[a];
  endfunction

  function automatic logic [DW-1:0] exp_rd_b(input int a);
    if (!active && bus0.rf_wr && a == int'(bus0.adr_x)) return bus0.din;
    return exp_rd(a);
  endfunction

  function automatic logic [37:0] exp_vec();
    int ax, ay;
    logic wd;
    ax = int'(bus0.adr_x);
    ay = int'(bus0.adr_y);
    wd = bus0.rf_wr & active;
    return {exp_rd(ax), exp_rd(ay), exp_rd_b(ax), exp_rd_b(ay),
            active, done_e, wd, active, done_e, wd};
  endfunction

  task automatic cycle();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; ms[i] = '0; end
      active = 0; k = 0; done_e = 0;
    end else if (active) begin
      k++;
      done_e = (k == DEPTH);
      if (k == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (op == 1) ms[i] = post[i];
          else         mm[i] = post[i];
        end
        active = 0; k = 0;
      end
    end else begin
      done_e = 0;
      if (bus0.rf_wr) mm[bus0.adr_x] = bus0.din;
      if (bus0.clr_req || bus0.restore_req || bus0.save_req) begin
        active = 1; k = 0;
        op = bus0.clr_req ? 0 : (bus0.restore_req ? 2 : 1);
        for (int i = 0; i < DEPTH; i++)
          post[i] = (op == 0) ? '0 : ((op == 2) ? ms[i] : mm[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.rf_wr = 0; bus0.clr_req = 0; bus0.save_req = 0; bus0.restore_req = 0;
  endtask

  task automatic rnd_addr();
    bus0.adr_x = AW'($urandom_range(DEPTH - 1));
    bus0.adr_y = AW'($urandom_range(DEPTH - 1));
  endtask

  task automatic test_reset();
    idle_inputs(); bus0.din = '0; bus0.adr_x = '0; bus0.adr_y = '0;
    rst = 1; cycle(); cycle(); rst = 0;
    for (int a = 0; a < DEPTH; a++) begin
      bus0.adr_x = AW'(a); bus0.adr_y = AW'(DEPTH - 1 - a); #1;
      checks++;
      if ({bus0.dx_out, bus0.dy_out, bus1.dx_out, bus1.dy_out} !== 32'h0) begin
        errors++; $display("FAIL reset_read a=%0d got %h want 0", a,
                           {bus0.dx_out, bus0.dy_out, bus1.dx_out, bus1.dy_out});
      end
    end
    checks++;
    if ({bus0.busy, bus0.done, bus1.busy, bus1.done} !== 4'b0) begin
      errors++; $display("FAIL reset_status got %b want 0000",
                         {bus0.busy, bus0.done, bus1.busy, bus1.done});
    end
  endtask

  task automatic test_write_bypass();
    bus0.adr_x = 5'd3; bus0.adr_y = 5'd3; bus0.din = 8'hA5; bus0.rf_wr = 1; #1;
    checks++;
    if ({bus1.dx_out, bus1.dy_out} !== 16'hA5A5) begin
      errors++; $display("FAIL bypass_same_cycle got %h want a5a5", {bus1.dx_out, bus1.dy_out});
    end
    checks++;
    if (bus0.dx_out !== 8'h00) begin
      errors++; $display("FAIL nobypass_same_cycle got %h want 00", bus0.dx_out);
    end
    cycle(); bus0.rf_wr = 0; #1;
    checks++;
    if ({bus0.dx_out, bus1.dx_out} !== 16'hA5A5) begin
      errors++; $display("FAIL write_next_cycle got %h want a5a5", {bus0.dx_out, bus1.dx_out});
    end
  endtask

  task automatic test_random_rw();
    for (int n = 0; n < 400; n++) begin
      rnd_addr();
      bus0.din         = DW'($urandom);
      bus0.rf_wr       = ($urandom_range(2) != 0);
      bus0.clr_req     = ($urandom_range(60) == 0);
      bus0.save_req    = ($urandom_range(30) == 0);
      bus0.restore_req = ($urandom_range(30) == 0);
      if ($urandom_range(3) == 0) bus0.adr_y = bus0.adr_x;
      #1;
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL random_rw n=%0d got %h want %h", n, act_vec, exp_vec());
      end
      cycle();
    end
    idle_inputs();
    while (active) cycle();
    cycle();
  endtask

  task automatic test_save_clear_restore();
    int busy_cnt, done_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      bus0.adr_x = AW'(i); bus0.din = DW'(i + 1); bus0.rf_wr = 1; cycle();
    end
    idle_inputs();
    for (int s = 0; s < 3; s++) begin
      bus0.save_req = (s == 0); bus0.clr_req = (s == 1); bus0.restore_req = (s == 2);
      cycle(); idle_inputs();
      busy_cnt = 0; done_cnt = 0;
      for (int c = 1; c <= DEPTH + 1; c++) begin
        rnd_addr(); #1;
        checks++;
        if (act_vec !== exp_vec()) begin
          errors++; $display("FAIL sweep%0d c=%0d got %h want %h", s, c, act_vec, exp_vec());
        end
        if (bus0.busy) busy_cnt++;
        if (bus0.done && c == DEPTH + 1) done_cnt++;
        cycle();
      end
      checks++;
      if (busy_cnt != DEPTH || done_cnt != 1) begin
        errors++; $display("FAIL sweep%0d_timing busy=%0d done=%0d want %0d 1",
                           s, busy_cnt, done_cnt, DEPTH);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      bus0.adr_x = AW'(a); #1;
      checks++;
      if (bus0.dx_out !== DW'(a + 1)) begin
        errors++; $display("FAIL restored a=%0d got %h want %h", a, bus0.dx_out, DW'(a + 1));
      end
    end
  endtask

  task automatic test_drop_and_priority();
    bus0.save_req = 1; cycle(); idle_inputs();
    repeat (5) cycle();
    bus0.adr_x = 5'd5; bus0.din = 8'hEE; bus0.rf_wr = 1; #1;
    checks++;
    if ({bus0.wr_drop, bus1.wr_drop} !== 2'b11 || bus1.dx_out !== 8'h06) begin
      errors++; $display("FAIL wr_drop got %b/%h want 11/06", {bus0.wr_drop, bus1.wr_drop}, bus1.dx_out);
    end
    cycle(); bus0.rf_wr = 0;
    while (active) cycle();
    cycle(); #1;
    checks++;
    if (bus0.dx_out !== 8'h06) begin
      errors++; $display("FAIL drop_r5 got %h want 06", bus0.dx_out);
    end
    bus0.clr_req = 1; bus0.save_req = 1; cycle(); idle_inputs();
    while (active) cycle();
    cycle();
    bus0.restore_req = 1; cycle(); idle_inputs();
    for (int c = 0; c <= DEPTH; c++) begin
      rnd_addr(); #1;
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL clr_prio c=%0d got %h want %h", c, act_vec, exp_vec());
      end
      cycle();
    end
    bus0.adr_x = 5'd5; bus0.adr_y = 5'd31; #1;
    checks++;
    if ({bus0.dx_out, bus0.dy_out} !== 16'h0620) begin
      errors++; $display("FAIL clr_only got %h want 0620", {bus0.dx_out, bus0.dy_out});
    end
  endtask

  task automatic test_reset_mid_sweep();
    bus0.restore_req = 1; cycle(); idle_inputs();
    repeat (10) cycle();
    rst = 1; cycle(); rst = 0;
    checks++;
    if ({bus0.busy, bus0.done, bus1.busy, bus1.done} !== 4'b0) begin
      errors++; $display("FAIL rst_mid_status got %b want 0000", {bus0.busy, bus0.done, bus1.busy, bus1.done});
    end
    for (int a = 0; a < DEPTH; a++) begin
      bus0.adr_x = AW'(a); #1;
      checks++;
      if ({bus0.dx_out, bus1.dx_out} !== 16'h0) begin
        errors++; $display("FAIL rst_mid_main a=%0d got %h want 0", a, {bus0.dx_out, bus1.dx_out});
      end
    end
    bus0.adr_x = 5'd7; bus0.din = 8'h33; bus0.rf_wr = 1; cycle(); idle_inputs();
    bus0.restore_req = 1; cycle(); idle_inputs();
    while (active) cycle();
    bus0.adr_x = 5'd7; #1;
    checks++;
    if (bus0.dx_out !== 8'h00) begin
      errors++; $display("FAIL rst_mid_shadow got %h want 00", bus0.dx_out);
    end
  endtask

  task automatic test_write_with_save();
    bus0.adr_x = 5'd0; bus0.din = 8'h5A; bus0.rf_wr = 1; bus0.save_req = 1;
    cycle(); idle_inputs();
    while (active) cycle();
    bus0.adr_x = 5'd0; bus0.din = 8'h00; bus0.rf_wr = 1; cycle(); idle_inputs();
    bus0.restore_req = 1; cycle(); idle_inputs();
    while (active) cycle();
    bus0.adr_x = 5'd0; #1;
    checks++;
    if (bus0.dx_out !== 8'h5A) begin
      errors++; $display("FAIL write_with_save got %h want 5a", bus0.dx_out);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_random_rw();
    rst = 1; cycle(); rst = 0;
    test_save_clear_restore();
    test_drop_and_priority();
    test_reset_mid_sweep();
    test_write_with_save();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
